// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: major opcodes, ALU operation codes,
// branch/load/store sub-function codes, the packed decode result carried
// through the stage, and the funct3 -> ALU operation mapping used by both
// OP and OP-IMM.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALUOP_NOP    = 4'h0;
  localparam logic [3:0] ALUOP_ADD    = 4'h1;
  localparam logic [3:0] ALUOP_SUB    = 4'h2;
  localparam logic [3:0] ALUOP_SLL    = 4'h3;
  localparam logic [3:0] ALUOP_SLT    = 4'h4;
  localparam logic [3:0] ALUOP_SLTU   = 4'h5;
  localparam logic [3:0] ALUOP_XOR    = 4'h6;
  localparam logic [3:0] ALUOP_SRL    = 4'h7;
  localparam logic [3:0] ALUOP_SRA    = 4'h8;
  localparam logic [3:0] ALUOP_OR     = 4'h9;
  localparam logic [3:0] ALUOP_AND    = 4'hA;
  localparam logic [3:0] ALUOP_PASS_B = 4'hB;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  aluop;
    logic        r1_en;
    logic        r2_en;
    logic        w_en;
    logic        imm_en;
    logic        pc_en;
    logic        jump_en;
    logic        branch_en;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  func3;
    logic        illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

  // alt selects sub/sra (funct7[5]); callers gate it where it is not legal.
  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_f3 = alt ? ALUOP_SUB : ALUOP_ADD;
      3'b001:  alu_f3 = ALUOP_SLL;
      3'b010:  alu_f3 = ALUOP_SLT;
      3'b011:  alu_f3 = ALUOP_SLTU;
      3'b100:  alu_f3 = ALUOP_XOR;
      3'b101:  alu_f3 = alt ? ALUOP_SRA : ALUOP_SRL;
      3'b110:  alu_f3 = ALUOP_OR;
      default: alu_f3 = ALUOP_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I decoder.
//   i_instr : raw 32-bit instruction
//   o_dec   : decoded bundle (register addresses, immediate, ALU op, enables,
//             func3, illegal flag)
module rv32i_decode_comb
  import rv32i_pkg::*;
(
  input  logic [31:0] i_instr,
  output dec_t        o_dec
);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_ill;
  dec_t       w_d;

  assign w_opc = i_instr[6:0];
  assign w_f3  = i_instr[14:12];
  assign w_f7  = i_instr[31:25];

  always_comb begin
    w_d       = '0;
    w_ill     = 1'b0;
    // Address fields always mirror the instruction, used or not.
    w_d.rs1   = i_instr[19:15];
    w_d.rs2   = i_instr[24:20];
    w_d.rd    = i_instr[11:7];
    w_d.func3 = w_f3;
    case (w_opc)
      OPC_OP: begin
        w_d.r1_en = 1'b1;
        w_d.r2_en = 1'b1;
        w_d.w_en  = 1'b1;
        w_d.aluop = alu_f3(w_f3, w_f7[5]);
        if (w_f7 != 7'h00 && w_f7 != 7'h20) w_ill = 1'b1;
        if (w_f7 == 7'h20 && w_f3 != 3'b000 && w_f3 != 3'b101) w_ill = 1'b1;
      end
      OPC_OP_IMM: begin
        w_d.r1_en  = 1'b1;
        w_d.w_en   = 1'b1;
        w_d.imm_en = 1'b1;
        w_d.imm    = {{20{i_instr[31]}}, i_instr[31:20]};
        // funct7 only means something for shifts; addi has no sub form.
        w_d.aluop  = alu_f3(w_f3, (w_f3 == 3'b101) && w_f7[5]);
        if (w_f3 == 3'b001 && w_f7 != 7'h00) w_ill = 1'b1;
        if (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20) w_ill = 1'b1;
      end
      OPC_LOAD: begin
        w_d.r1_en  = 1'b1;
        w_d.w_en   = 1'b1;
        w_d.imm_en = 1'b1;
        w_d.mem_rd = 1'b1;
        w_d.imm    = {{20{i_instr[31]}}, i_instr[31:20]};
        w_d.aluop  = ALUOP_ADD;
        if (!(w_f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU})) w_ill = 1'b1;
      end
      OPC_STORE: begin
        w_d.r1_en  = 1'b1;
        w_d.r2_en  = 1'b1;
        w_d.imm_en = 1'b1;
        w_d.mem_wr = 1'b1;
        w_d.imm    = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        w_d.aluop  = ALUOP_ADD;
        if (!(w_f3 inside {F3_SB, F3_SH, F3_SW})) w_ill = 1'b1;
      end
      OPC_BRANCH: begin
        w_d.r1_en     = 1'b1;
        w_d.r2_en     = 1'b1;
        w_d.branch_en = 1'b1;
        w_d.imm       = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
        w_d.aluop     = ALUOP_NOP;
        if (!(w_f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU}))
          w_ill = 1'b1;
      end
      OPC_LUI: begin
        w_d.w_en   = 1'b1;
        w_d.imm_en = 1'b1;
        w_d.imm    = {i_instr[31:12], 12'h000};
        w_d.aluop  = ALUOP_PASS_B;
      end
      OPC_AUIPC: begin
        w_d.w_en   = 1'b1;
        w_d.imm_en = 1'b1;
        w_d.pc_en  = 1'b1;
        w_d.imm    = {i_instr[31:12], 12'h000};
        w_d.aluop  = ALUOP_ADD;
      end
      OPC_JAL: begin
        w_d.w_en    = 1'b1;
        w_d.imm_en  = 1'b1;
        w_d.pc_en   = 1'b1;
        w_d.jump_en = 1'b1;
        w_d.imm     = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
        w_d.aluop   = ALUOP_ADD;
      end
      OPC_JALR: begin
        w_d.r1_en   = 1'b1;
        w_d.w_en    = 1'b1;
        w_d.imm_en  = 1'b1;
        w_d.jump_en = 1'b1;
        w_d.imm     = {{20{i_instr[31]}}, i_instr[31:20]};
        w_d.aluop   = ALUOP_ADD;
        if (w_f3 != 3'b000) w_ill = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
    if (i_instr[1:0] != 2'b11) w_ill = 1'b1;
    // Illegal beats still flow so execute can trap, but must not act.
    if (w_ill) begin
      w_d.r1_en     = 1'b0;
      w_d.r2_en     = 1'b0;
      w_d.w_en      = 1'b0;
      w_d.imm_en    = 1'b0;
      w_d.pc_en     = 1'b0;
      w_d.jump_en   = 1'b0;
      w_d.branch_en = 1'b0;
      w_d.mem_rd    = 1'b0;
      w_d.mem_wr    = 1'b0;
      w_d.aluop     = ALUOP_NOP;
    end
    if (w_d.rd == 5'd0) w_d.w_en = 1'b0;
    w_d.illegal = w_ill;
    o_dec = w_d;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage between fetch and execute.
// Inputs : clk, rst_n (async low), flush, in_valid/instr/in_pc, out_ready.
// Outputs: in_ready, out_valid/out_pc and the decoded fields (register
//          addresses, imm, aluop, operand/control enables, func3, illegal).
// An output register plus one skid register give two entries of buffering so
// in_ready can be a pure register output, independent of out_ready.
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [XLEN-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [4:0]         rs1_addr,
  output logic [4:0]         rs2_addr,
  output logic [4:0]         rd_addr,
  output logic [XLEN-1:0]    imm,
  output logic [ALUOP_W-1:0] aluop,
  output logic               r1_en,
  output logic               r2_en,
  output logic               w_en,
  output logic               imm_en,
  output logic               pc_en,
  output logic               jump_en,
  output logic               branch_en,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [2:0]         func3,
  output logic               illegal
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("decode_stage: only XLEN=32 is supported");
  end
  if (ALUOP_W < 4) begin : g_bad_aluop_w
    $error("decode_stage: ALUOP_W must be >= 4");
  end

  dec_t            w_dec;
  dec_t            r_out;
  dec_t            r_skid;
  logic [XLEN-1:0] r_out_pc;
  logic [XLEN-1:0] r_skid_pc;
  logic            r_out_valid;
  logic            r_skid_valid;
  logic            w_in_fire;
  logic            w_out_free;

  rv32i_decode_comb u_dec (
    .i_instr (instr),
    .o_dec   (w_dec)
  );

  assign in_ready   = !r_skid_valid;
  assign w_in_fire  = in_valid && in_ready;
  // Output register can take a new beat this edge (empty or being consumed).
  assign w_out_free = !r_out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
      r_out_pc     <= '0;
      r_skid_pc    <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        // in_ready is low here, so no incoming beat competes with the drain.
        r_out        <= r_skid;
        r_out_pc     <= r_skid_pc;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) begin
          r_out    <= w_dec;
          r_out_pc <= in_pc;
        end
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_pc    <= in_pc;
      r_skid_valid <= 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_pc    = r_out_pc;
  assign rs1_addr  = r_out.rs1;
  assign rs2_addr  = r_out.rs2;
  assign rd_addr   = r_out.rd;
  assign imm       = r_out.imm;
  assign aluop     = ALUOP_W'(r_out.aluop);
  assign r1_en     = r_out.r1_en;
  assign r2_en     = r_out.r2_en;
  assign w_en      = r_out.w_en;
  assign imm_en    = r_out.imm_en;
  assign pc_en     = r_out.pc_en;
  assign jump_en   = r_out.jump_en;
  assign branch_en = r_out.branch_en;
  assign mem_rd    = r_out.mem_rd;
  assign mem_wr    = r_out.mem_wr;
  assign func3     = r_out.func3;
  assign illegal   = r_out.illegal;

endmodule
